// File: rtl/gen_scheduler.sv
// gen_scheduler: decides when the Game of Life board advances a generation
// or reloads from a seed. The ping-pong buffer flips only on a frame tick, so
// the renderer never shows a half-written board.
// Optional feature macro: GEN_SCHED_STATS_EN (generation counter + sample pulse).
module gen_scheduler #(
    parameter int FRAME_CNT_W         = 6,
    parameter int GEN_CNT_W           = 16,
    parameter int MAX_SPEED           = 32,
    parameter int SPEED_W             = 5,
    parameter int LOG_NUM_SEED        = 3,
    parameter int GRAPH_SAMPLE_PERIOD = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    vsync_in,
    input  logic [SPEED_W-1:0]      speed_in,
    input  logic                    pause_in,
    input  logic                    step_in,
    input  logic                    seed_load_in,
    input  logic [LOG_NUM_SEED-1:0] seed_idx_in,
    input  logic                    update_done_in,
    input  logic                    seed_done_in,
    output logic                    update_start_out,
    output logic                    seed_start_out,
    output logic [LOG_NUM_SEED-1:0] seed_idx_out,
    output logic                    buffer_sel_out,
    output logic                    busy_out,
    output logic [GEN_CNT_W-1:0]    gen_count_out,
    output logic                    sample_out
);

    typedef enum logic [1:0] {IDLE, SEED, RUN, SWAP} state_t;

    state_t                  state_q, state_d;
    logic                    vsync_q, tick_q;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic                    pend_q, pend_d;
    logic [LOG_NUM_SEED-1:0] pend_idx_q, pend_idx_d;
    logic [LOG_NUM_SEED-1:0] seed_idx_q, seed_idx_d;
    logic                    buf_q, buf_d;
    logic                    upd_start_q, upd_start_d;
    logic                    seed_start_q, seed_start_d;
    logic [FRAME_CNT_W-1:0]  fpg;
    logic                    seed_req;

    // Frames per generation; speed is sampled live every comparison.
    assign fpg      = FRAME_CNT_W'(MAX_SPEED) - FRAME_CNT_W'(speed_in);
    // A fresh pulse in IDLE counts as a request just like a queued one.
    assign seed_req = pend_q | seed_load_in;

`ifdef GEN_SCHED_STATS_EN
    logic                 reseed_q, reseed_d;
    logic [GEN_CNT_W-1:0] gen_q, gen_d;
    logic                 sample_q, sample_d;
`endif

    // Next-state logic: scheduling FSM, seed queueing and buffer flip.
    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        pend_d       = pend_q;
        pend_idx_d   = pend_idx_q;
        seed_idx_d   = seed_idx_q;
        buf_d        = buf_q;
        upd_start_d  = 1'b0;
        seed_start_d = 1'b0;
`ifdef GEN_SCHED_STATS_EN
        reseed_d     = reseed_q;
        gen_d        = gen_q;
        sample_d     = 1'b0;
`endif
        // Requests arriving while busy collapse into one; latest index wins.
        if (state_q != IDLE && seed_load_in) begin
            pend_d     = 1'b1;
            pend_idx_d = seed_idx_in;
        end
        case (state_q)
            IDLE: begin
                if (tick_q && frame_cnt_q != '1)
                    frame_cnt_d = frame_cnt_q + 1'b1;
                if (seed_req) begin
                    state_d      = SEED;
                    seed_idx_d   = seed_load_in ? seed_idx_in : pend_idx_q;
                    seed_start_d = 1'b1;
                    pend_d       = 1'b0;
                end else if ((!pause_in && frame_cnt_q >= fpg) || (pause_in && step_in)) begin
                    state_d     = RUN;
                    upd_start_d = 1'b1;
                    frame_cnt_d = '0;
                end
            end
            SEED: begin
                // Done coincident with our own start pulse is stale.
                if (seed_done_in && !seed_start_q) begin
                    state_d  = SWAP;
`ifdef GEN_SCHED_STATS_EN
                    reseed_d = 1'b1;
`endif
                end
            end
            RUN: begin
                if (update_done_in && !upd_start_q)
                    state_d = SWAP;
            end
            SWAP: begin
                if (tick_q) begin
                    state_d     = IDLE;
                    buf_d       = ~buf_q;
                    frame_cnt_d = '0;
`ifdef GEN_SCHED_STATS_EN
                    if (reseed_q) begin
                        gen_d    = '0;
                        reseed_d = 1'b0;
                    end else begin
                        gen_d    = gen_q + 1'b1;
                        sample_d = ((32'(gen_d)) % GRAPH_SAMPLE_PERIOD) == 0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b1;
            tick_q       <= 1'b0;
            frame_cnt_q  <= '0;
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            seed_idx_q   <= '0;
            buf_q        <= 1'b0;
            upd_start_q  <= 1'b0;
            seed_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_in;
            tick_q       <= vsync_q & ~vsync_in;
            frame_cnt_q  <= frame_cnt_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            seed_idx_q   <= seed_idx_d;
            buf_q        <= buf_d;
            upd_start_q  <= upd_start_d;
            seed_start_q <= seed_start_d;
        end
    end

`ifdef GEN_SCHED_STATS_EN
    // Generation statistics registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            reseed_q <= 1'b0;
            gen_q    <= '0;
            sample_q <= 1'b0;
        end else begin
            reseed_q <= reseed_d;
            gen_q    <= gen_d;
            sample_q <= sample_d;
        end
    end
    assign gen_count_out = gen_q;
    assign sample_out    = sample_q;
`else
    assign gen_count_out = '0;
    assign sample_out    = 1'b0;
`endif

    assign update_start_out = upd_start_q;
    assign seed_start_out   = seed_start_q;
    assign seed_idx_out     = seed_idx_q;
    assign buffer_sel_out   = buf_q;
    assign busy_out         = (state_q != IDLE);

endmodule

// File: tb/tb_gen_scheduler.sv
// Bench for gen_scheduler: speed table, pause/step, seed collision, stats.
// Swap results are predicted when done is driven and compared on each flip.
module tb_gen_scheduler;

    localparam int FRAME    = 160;
    localparam int UPD_LAT  = 100;
    localparam int SEED_LAT = 50;
`ifdef GEN_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n_in, vsync_in, pause_in, step_in, seed_load_in;
    logic [4:0]  speed_in;
    logic [2:0]  seed_idx_in;
    logic        update_done_in, seed_done_in;
    logic        update_start_out, seed_start_out, buffer_sel_out, busy_out, sample_out;
    logic [2:0]  seed_idx_out;
    logic [15:0] gen_count_out;

    gen_scheduler #(.GRAPH_SAMPLE_PERIOD(2)) dut (
        .clk_in(clk), .rst_n_in(rst_n_in), .vsync_in(vsync_in), .speed_in(speed_in),
        .pause_in(pause_in), .step_in(step_in), .seed_load_in(seed_load_in),
        .seed_idx_in(seed_idx_in), .update_done_in(update_done_in),
        .seed_done_in(seed_done_in), .update_start_out(update_start_out),
        .seed_start_out(seed_start_out), .seed_idx_out(seed_idx_out),
        .buffer_sel_out(buffer_sel_out), .busy_out(busy_out),
        .gen_count_out(gen_count_out), .sample_out(sample_out));

    always #5 clk = ~clk;

    typedef struct { logic b; int g; logic s; } swap_t;
    typedef struct { int speed; int frames; } vec_t;

    swap_t sb_q[$];
    int    st_t[$];
    int    checks = 0, failures = 0;
    int    cyc = 0, seed_t = -1, flip_t = -1, flips = 0, samples = 0;
    logic  prev_buf = 1'b0, prev_us = 1'b0;
    logic  exp_b = 1'b0;
    int    exp_g = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // VGA-like vsync: low for 4 cycles every FRAME cycles.
    initial begin
        vsync_in = 1'b1;
        forever begin
            repeat (FRAME - 4) @(posedge clk);
            #1 vsync_in = 1'b0;
            repeat (4) @(posedge clk);
            #1 vsync_in = 1'b1;
        end
    end

    // Datapath model: answers each start with done after a fixed latency and
    // predicts the outcome of the swap that done will cause.
    initial begin
        int ut, stt;
        ut = 0; stt = 0;
        update_done_in = 1'b0;
        seed_done_in   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            update_done_in = 1'b0;
            seed_done_in   = 1'b0;
            if (!rst_n_in) begin ut = 0; stt = 0; end
            if (ut > 0) begin
                ut--;
                if (ut == 0) begin
                    update_done_in = 1'b1;
                    exp_b = ~exp_b;
                    exp_g = (exp_g + 1) % 65536;
                    sb_q.push_back('{exp_b, STATS ? exp_g : 0, STATS && (exp_g % 2 == 0)});
                end
            end
            if (stt > 0) begin
                stt--;
                if (stt == 0) begin
                    seed_done_in = 1'b1;
                    exp_b = ~exp_b;
                    exp_g = 0;
                    sb_q.push_back('{exp_b, 0, 1'b0});
                end
            end
            if (update_start_out) ut = UPD_LAT;
            if (seed_start_out) stt = SEED_LAT;
        end
    end

    // Monitor: logs start pulses and checks every buffer flip against the queue.
    initial begin
        swap_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n_in) begin
                if (update_start_out) begin
                    st_t.push_back(cyc);
                    if (prev_us) chk("start_width", 2, 1);
                end
                if (seed_start_out) seed_t = cyc;
                if (buffer_sel_out != prev_buf) begin
                    flips++;
                    flip_t = cyc;
                    if (sb_q.size() == 0) chk("unexpected_swap", 1, 0);
                    else begin
                        e = sb_q.pop_front();
                        chk("swap_buf", int'(buffer_sel_out), int'(e.b));
                        chk("swap_gen", int'(gen_count_out), e.g);
                        chk("swap_sample", int'(sample_out), int'(e.s));
                    end
                end else if (sample_out) chk("sample_no_swap", 1, 0);
                if (sample_out) samples++;
            end
            prev_buf = buffer_sel_out;
            prev_us  = update_start_out;
        end
    end

    task automatic wait_starts(input int target, input int budget, output bit ok);
        ok = 1'b1;
        while (st_t.size() < target) begin
            if (budget == 0) begin
                ok = 1'b0;
                chk("timeout_starts", st_t.size(), target);
                break;
            end
            budget--;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget);
        while (busy_out) begin
            if (budget == 0) begin
                chk("timeout_idle", 1, 0);
                break;
            end
            budget--;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 step_in = 1'b1;
        @(posedge clk); #1 step_in = 1'b0;
    endtask

    initial begin
        vec_t vecs[4];
        bit   ok;
        int   n, f, s0;
        vecs[0] = '{31, 2};
        vecs[1] = '{28, 5};
        vecs[2] = '{30, 3};
        vecs[3] = '{26, 7};

        rst_n_in = 1'b0; pause_in = 1'b1; speed_in = 5'd31; step_in = 1'b0;
        seed_load_in = 1'b0; seed_idx_in = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_update_start", int'(update_start_out), 0);
        chk("rst_seed_start", int'(seed_start_out), 0);
        chk("rst_seed_idx", int'(seed_idx_out), 0);
        chk("rst_buffer_sel", int'(buffer_sel_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_gen_count", int'(gen_count_out), 0);
        chk("rst_sample", int'(sample_out), 0);
        @(posedge clk); #1 rst_n_in = 1'b1;

        repeat (10 * FRAME) @(posedge clk);
        chk("paused_no_start", st_t.size(), 0);
        chk("paused_busy", int'(busy_out), 0);

        // Start spacing is (fpg + 1) frames: fpg counted ticks plus the swap frame.
        #1 pause_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            speed_in = 5'(vecs[i].speed);
            n = st_t.size();
            wait_starts(n + 3, (vecs[i].frames * 4 + 4) * FRAME, ok);
            if (ok) chk($sformatf("spacing_spd%0d", vecs[i].speed),
                        st_t[n + 2] - st_t[n + 1], vecs[i].frames * FRAME);
        end

        // Pause then a single step; a step during RUN must not queue.
        @(posedge clk); #1 pause_in = 1'b1;
        wait_idle(4 * FRAME);
        repeat (FRAME) @(posedge clk);
        n = st_t.size();
        f = flips;
        pulse_step();
        repeat (3) @(posedge clk);
        chk("step_one_start", st_t.size(), n + 1);
        chk("step_busy", int'(busy_out), 1);
        pulse_step();
        wait_idle(3 * FRAME);
        chk("step_one_swap", flips, f + 1);
        repeat (2 * FRAME) @(posedge clk);
        chk("step_no_second", st_t.size(), n + 1);

        // Seed request during RUN is served on the first IDLE cycle after the swap.
        n = st_t.size();
        seed_t = -1;
        pulse_step();
        repeat (3) @(posedge clk);
        #1 seed_idx_in = 3'd5; seed_load_in = 1'b1;
        @(posedge clk); #1 seed_load_in = 1'b0;
        begin
            int b;
            b = 3 * FRAME;
            while (seed_t < 0 && b > 0) begin b--; @(negedge clk); end
            if (seed_t < 0) chk("timeout_seed", 0, 1);
            else begin
                chk("seed_idx", int'(seed_idx_out), 5);
                chk("seed_after_swap", seed_t - flip_t, 1);
            end
        end
        wait_idle(3 * FRAME);
        chk("seed_gen_zero", int'(gen_count_out), 0);
        chk("seed_no_extra_gen", st_t.size(), n + 1);
        chk("seed_sb_empty", sb_q.size(), 0);

        // Six generations after reseed: samples on 2, 4, 6 when stats are built.
        s0 = samples;
        @(posedge clk); #1 speed_in = 5'd31; pause_in = 1'b0;
        n = st_t.size();
        wait_starts(n + 6, 16 * FRAME, ok);
        #1 pause_in = 1'b1;
        wait_idle(3 * FRAME);
        chk("sample_count", samples - s0, STATS ? 3 : 0);

        repeat (FRAME) @(posedge clk);
        chk("final_sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
